// File: rtl/uart_cmd_pkg.sv
// Purpose: shared types and command codes for the UART command receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam logic [7:0] CMD_X0 = 8'h78;
    localparam logic [7:0] CMD_Y0 = 8'h79;
    localparam logic [7:0] CMD_Z0 = 8'h7A;
    localparam logic [7:0] CMD_X1 = 8'h58;
    localparam logic [7:0] CMD_Y1 = 8'h59;
    localparam logic [7:0] CMD_Z1 = 8'h5A;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_X0) || (b == CMD_Y0) || (b == CMD_Z0) ||
               (b == CMD_X1) || (b == CMD_Y1) || (b == CMD_Z1);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Purpose: bit-period counter; cleared by restart, flags the sampling point and the last cycle of a bit.
// Latency: half_tick fires HALF+SAMPLE_OFS cycles after the cycle following restart.
// Backpressure: none; free-running counter.
// Ports: clk, rst_n, restart (clear counter next edge), half_tick (sample point), div_tick (cnt == DIV-1).
module uart_bit_timer #(
    parameter int DIV        = 5208,
    parameter int SAMPLE_OFS = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic half_tick,
    output logic div_tick
);
    import uart_cmd_pkg::*;

    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign half_tick = (cnt == CW'(HALF + SAMPLE_OFS));
    assign div_tick  = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_cmd_rx.sv
// Purpose: 8N1 UART receiver with command-byte detection; UART_CMD_RX_MAJORITY_EN selects 2-of-3 bit voting.
// Latency: rx_valid/frame_err on the stop-bit sample, ~9.5 bit times after the start edge (+1 cycle with voting).
// Backpressure: none; rx_data is held until the next frame completes, pulses are single-cycle.
// Ports: clk, rst_n, uart_rx (async line) -> rx_data, rx_int, rx_valid, frame_err, cmd_hit.
module uart_cmd_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       cmd_hit
);
    import uart_cmd_pkg::*;

    localparam int DIV = CLK_HZ / BAUD;
`ifdef UART_CMD_RX_MAJORITY_EN
    // Vote needs the sample after HALF, so the decision moves one cycle later.
    localparam int SAMPLE_OFS = 1;
`else
    localparam int SAMPLE_OFS = 0;
`endif

    logic sync1, rx_s, rx_prev;
    logic rx_bit, fall;
    logic half_tick, div_tick, restart;

    rx_state_t  state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n, data_n;
    logic       int_n, valid_n, ferr_n, hit_n;

    // Synchronizer plus one history stage for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= uart_rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

`ifdef UART_CMD_RX_MAJORITY_EN
    // At the decision cycle hist holds the samples from HALF-1 and HALF.
    logic [1:0] hist;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end
    assign rx_bit = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign rx_bit = rx_s;
`endif

    assign fall = rx_prev & ~rx_s;

    uart_bit_timer #(
        .DIV        (DIV),
        .SAMPLE_OFS (SAMPLE_OFS)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .half_tick (half_tick),
        .div_tick  (div_tick)
    );

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        data_n    = rx_data;
        int_n     = rx_int;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        hit_n     = 1'b0;
        // Wrapping on div_tick keeps successive sample points exactly DIV apart.
        restart   = div_tick;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_n   = START;
                    bit_cnt_n = 3'd0;
                    restart   = 1'b1;
                end
            end
            START: begin
                if (half_tick) begin
                    if (!rx_bit) begin
                        state_n = DATA;
                        int_n   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (half_tick) begin
                    shift_n   = {rx_bit, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (half_tick) begin
                    int_n = 1'b0;
                    if (rx_bit) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        hit_n   = is_cmd(shift);
                        state_n = IDLE;
                    end else begin
                        data_n  = 8'h00;
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A line stuck low must not look like a new start edge.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_int    <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            cmd_hit   <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            rx_data   <= data_n;
            rx_int    <= int_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
            cmd_hit   <= hit_n;
        end
    end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
- REQ-001: Parameter CLK_HZ, default 50000000; system clock frequency in Hz.
- REQ-002: Parameter BAUD, default 9600; serial bit rate.
- REQ-003: clk  input  1  system clock; all logic on rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous, active-low.
- REQ-005: uart_rx  input  1  asynchronous serial line; idle high; 8N1 frames, LSB first.
- REQ-006: rx_data  output  8  last received byte, held until the next frame completes.
- REQ-007: rx_int  output  1  high while a validated frame is in progress; its falling edge marks rx_data as updated.
- REQ-008: rx_valid  output  1  one-cycle pulse when a good frame completes.
- REQ-009: frame_err  output  1  one-cycle pulse when a frame ends with stop bit 0.
- REQ-010: cmd_hit  output  1  high with rx_valid when rx_data is 0x78, 0x79, 0x7A, 0x58, 0x59 or 0x5A; otherwise 0.

Function
- REQ-011: uart_rx SHALL pass through a 2-FF synchronizer; all sampling uses the synchronized value.
- REQ-012: Bit period DIV SHALL be CLK_HZ/BAUD (integer truncation); mid-bit point HALF SHALL be DIV/2.
- REQ-013: The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
- REQ-014: IDLE SHALL move to START on a synchronized high-to-low transition and clear the bit counter.
- REQ-015: START SHALL sample at HALF; a low sample moves to DATA and sets rx_int; a high sample returns to IDLE without touching any output.
- REQ-016: DATA SHALL take 8 samples, DIV cycles apart, starting DIV after the start sample, shifting LSB first, then move to STOP.
- REQ-017: On a high stop sample, STOP SHALL load rx_data, pulse rx_valid, drive cmd_hit and clear rx_int on the same clock edge, then enter IDLE.
- REQ-018: On a low stop sample, STOP SHALL set rx_data to 0x00, pulse frame_err, clear rx_int and hold rx_valid at 0, then enter WAIT_IDLE.
- REQ-019: WAIT_IDLE SHALL return to IDLE only after a synchronized high is seen; a line held low SHALL NOT start a frame.
- REQ-020: Back-to-back frames SHALL be accepted; a start edge arriving any time after the stop sample is detected.
- REQ-021: rx_data SHALL change only on the edge that completes or fails a frame.

Reset
- REQ-022: On rst_n low, rx_data SHALL be 0x00; rx_int, rx_valid, frame_err and cmd_hit SHALL be 0; synchronizer flops SHALL be 1; FSM SHALL be IDLE; counters SHALL be 0.
- REQ-023: Reset asserted mid-frame SHALL abort the frame with no pulse; the next complete frame after release SHALL be received correctly.

Configuration
- REQ-024: With UART_CMD_RX_MAJORITY_EN defined, each bit (start, data, stop) SHALL be the 2-of-3 majority of samples at HALF-1, HALF and HALF+1, and the decision SHALL be made at HALF+1.
- REQ-025: Without UART_CMD_RX_MAJORITY_EN, each bit SHALL be the single sample at HALF.

Structure
- REQ-026: A shared package uart_cmd_pkg SHALL hold the FSM state enum and the six command code constants (CMD_X0=0x78, CMD_Y0=0x79, CMD_Z0=0x7A, CMD_X1=0x58, CMD_Y1=0x59, CMD_Z1=0x5A).
- REQ-027: Bit timing SHALL live in sub-module uart_bit_timer (counter; restart input; HALF and DIV tick outputs).

Verification (CLK_HZ=50000000, BAUD=9600: DIV=5208, HALF=2604)
- REQ-028: Frame 0x78 -> rx_int rises about 2606 cycles after the start edge; rx_data=0x78; one-cycle rx_valid; cmd_hit=1; rx_int falls with rx_valid.
- REQ-029: Frame 0x41 -> rx_data=0x41; rx_valid pulse; cmd_hit=0.
- REQ-030: 1000-cycle low glitch on an idle line -> rx_int stays 0, no pulses, FSM back in IDLE.
- REQ-031: Frame 0x5A with stop bit 0, then line held low for 3 bit times -> one frame_err pulse; rx_data=0x00; no rx_valid; no new frame until the line goes high; a following 0x59 is received correctly.
- REQ-032: rst_n pulsed during data bit 4 of 0x79 -> all outputs at reset values; the next 0x7A frame is received as 0x7A.
- REQ-033: Frame 0x79 with a 1-cycle inverted glitch at the HALF point of bit 3 -> 0x79 with UART_CMD_RX_MAJORITY_EN defined; 0x71 without it.
